l2_tcdm_arbiter: RTL and testbench
==================================

// Module: l2_tcdm_arbiter
// PURPOSE
//  Shares one single-ported L2 TCDM/lint slave port among NB_MASTERS lint masters
//  (master 0 = JTAG lint bridge, others = SoC requesters).
//  Round-robin request arbitration, combinational grant forwarding, and a response
//  tracker that returns read data/r_valid to the granted master after MEM_LATENCY cycles.
//  Sits between the lint masters and l2_ram_multi_bank.mem_slave.
// PARAMETERS
//  NB_MASTERS   2   number of lint masters (>=2)
//  ADDR_WIDTH   32  address width
//  DATA_WIDTH   32  data width; BE width = DATA_WIDTH/8
//  MEM_LATENCY  1   cycles from slave grant to read data valid (>=1)
// PORTS
//  clk_i        in   1                  clock
//  rst_i        in   1                  synchronous reset, active-high
//  m_req_i      in   NB_MASTERS         per-master request
//  m_add_i      in   NB_MASTERS*ADDR_W  per-master address (packed, master 0 in LSBs)
//  m_wen_i      in   NB_MASTERS         per-master write enable, active-low (1=read)
//  m_wdata_i    in   NB_MASTERS*DATA_W  per-master write data
//  m_be_i       in   NB_MASTERS*BE_W    per-master byte enables
//  m_gnt_o      out  NB_MASTERS         per-master grant
//  m_r_valid_o  out  NB_MASTERS         per-master response valid
//  m_r_rdata_o  out  DATA_W             read data, shared by all masters
//  s_req_o      out  1                  slave request
//  s_add_o      out  ADDR_W             slave address
//  s_wen_o      out  1                  slave write enable, active-low
//  s_wdata_o    out  DATA_W             slave write data
//  s_be_o       out  BE_W               slave byte enables
//  s_gnt_i      in   1                  slave grant
//  s_r_rdata_i  in   DATA_W             slave read data
// BEHAVIOUR
//  - Arbitration (combinational): winner = first requesting master from rr_q upward,
//    modulo NB_MASTERS. s_req_o = |m_req_i & !rst_i. s_* = winner's fields; fields are 0
//    when no request is pending.
//  - m_gnt_o[winner] = s_gnt_i & s_req_o; other gnt bits are 0. Only one gnt bit is high per cycle.
//  - Transfer = s_req_o & s_gnt_i. On a transfer, rr_q <= (winner+1) mod NB_MASTERS.
//    No transfer: rr_q holds. A master holds its request and fields until granted.
//  - Response tracker: delay line of MEM_LATENCY stages {vld, id}. Each transfer, read or
//    write, enters {1,winner}. At the stage output, m_r_valid_o[id]=vld, a one-cycle pulse.
//    Writes get an r_valid, per lint convention. m_r_rdata_o = s_r_rdata_i, passed through unregistered.
//  - Throughput: one transfer per cycle. Back-to-back transfers from different masters
//    produce responses in order, one per cycle.
//  - Reset values: rr_q=0, all tracker vld=0, m_r_valid_o=0, m_gnt_o=0, s_req_o=0.
//  - Reset mid-operation: in-flight responses are dropped and no r_valid is emitted for
//    them. The first cycle after reset grants from master 0.
//  - Simultaneous request and grant on the same cycle as a response: independent, both
//    happen. Any master may receive gnt and r_valid in the same cycle.
//  - s_gnt_i low with requests pending: all m_gnt_o=0, rr_q and tracker hold and shift normally.
// CONFIGURATION
//  L2_ARB_JTAG_PRIO_EN defined: master 0 (JTAG) has absolute priority whenever
//    m_req_i[0]=1. The others are round-robin among themselves via rr_q; rr_q is updated
//    only on non-master-0 transfers.
//  L2_ARB_JTAG_PRIO_EN undefined: pure round-robin over all masters as above.
// TESTING
//  1. L2[0x10]=0xDEADBEEF; m0 reads 0x10, s_gnt_i=1 -> m_gnt_o=2'b01 same cycle;
//     m_r_valid_o=2'b01 and m_r_rdata_o=0xDEADBEEF exactly 1 cycle later; m1 sees no r_valid.
//  2. m0 and m1 request continuously for 6 cycles -> grants alternate 01,10,01,10,01,10;
//     six r_valid pulses in the same order, each 1 cycle after its grant.
//  3. Both masters request, s_gnt_i=0 for 3 cycles then 1 -> no m_gnt_o for 3 cycles;
//     rr_q unchanged; master 0 granted on cycle 4.
//  4. m1 writes 0x00000000 to 0x20 with be=4'hF, then writes 0xAABBCCDD with be=4'b0011,
//     then reads -> r_valid for each of the 3 transfers; read returns 0x0000CCDD.
//  5. rst_i pulsed the cycle after a read grant -> no m_r_valid_o follows;
//     next contention grants master 0 first.
//  6. With L2_ARB_JTAG_PRIO_EN: m0 and m1 request for 4 cycles -> m0 granted all 4, m1 waits.
//     Without the macro: 01,10,01,10.

Source files
------------

// File: rtl/l2_tcdm_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM slave port among lint masters, with response tracking.
// Define L2_ARB_JTAG_PRIO_EN to give master 0 (JTAG) absolute priority over the others.
module l2_tcdm_arbiter #(
  parameter int unsigned NB_MASTERS  = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NB_MASTERS-1:0]            m_req_i,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0] m_add_i,
  input  logic [NB_MASTERS-1:0]            m_wen_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NB_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  output logic [NB_MASTERS-1:0]            m_gnt_o,
  output logic [NB_MASTERS-1:0]            m_r_valid_o,
  output logic [DATA_WIDTH-1:0]            m_r_rdata_o,
  output logic                             s_req_o,
  output logic [ADDR_WIDTH-1:0]            s_add_o,
  output logic                             s_wen_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          s_be_o,
  input  logic                             s_gnt_i,
  input  logic [DATA_WIDTH-1:0]            s_r_rdata_i
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam int unsigned IdWidth = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  logic [IdWidth-1:0]   rr_q, rr_d;
  logic [IdWidth-1:0]   winner;
  logic [IdWidth:0]     cand_sum;
  logic [IdWidth:0]     next_sum;
  logic [IdWidth-1:0]   cand;
  logic                 found;
  logic                 eligible;
  logic                 xfer;
  logic [MEM_LATENCY-1:0] vld_q;
  logic [IdWidth-1:0]   id_q [MEM_LATENCY];

  assign s_req_o = (|m_req_i) & ~rst_i;
  assign xfer    = s_req_o & s_gnt_i;

  // Scan masters starting at rr_q, wrapping modulo NB_MASTERS; first requester wins.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    eligible = 1'b0;
`ifdef L2_ARB_JTAG_PRIO_EN
    if (m_req_i[0]) begin
      found = 1'b1;
    end
`endif
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      cand_sum = {1'b0, rr_q} + (IdWidth+1)'(i);
      if (cand_sum >= (IdWidth+1)'(NB_MASTERS)) begin
        cand_sum = cand_sum - (IdWidth+1)'(NB_MASTERS);
      end
      cand = cand_sum[IdWidth-1:0];
`ifdef L2_ARB_JTAG_PRIO_EN
      eligible = m_req_i[cand] && (cand != '0);
`else
      eligible = m_req_i[cand];
`endif
      if (!found && eligible) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    next_sum = {1'b0, winner} + (IdWidth+1)'(1);
    if (next_sum >= (IdWidth+1)'(NB_MASTERS)) begin
      next_sum = '0;
    end
    rr_d = rr_q;
`ifdef L2_ARB_JTAG_PRIO_EN
    if (xfer && (winner != '0)) begin
      rr_d = next_sum[IdWidth-1:0];
    end
`else
    if (xfer) begin
      rr_d = next_sum[IdWidth-1:0];
    end
`endif
  end

  always_comb begin
    s_add_o   = '0;
    s_wen_o   = 1'b0;
    s_wdata_o = '0;
    s_be_o    = '0;
    if (s_req_o) begin
      s_add_o   = m_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      s_wen_o   = m_wen_i[winner];
      s_wdata_o = m_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
      s_be_o    = m_be_i[winner*BeWidth +: BeWidth];
    end
  end

  always_comb begin
    m_gnt_o = '0;
    if (xfer) begin
      m_gnt_o[winner] = 1'b1;
    end
  end

  // Masked by reset so responses in flight when reset hits are never reported.
  always_comb begin
    m_r_valid_o = '0;
    if (vld_q[MEM_LATENCY-1] && !rst_i) begin
      m_r_valid_o[id_q[MEM_LATENCY-1]] = 1'b1;
    end
  end

  assign m_r_rdata_o = s_r_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      vld_q <= '0;
      for (int unsigned k = 0; k < MEM_LATENCY; k++) begin
        id_q[k] <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      vld_q[0] <= xfer;
      id_q[0]  <= winner;
      for (int unsigned k = 1; k < MEM_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_l2_tcdm_arbiter.sv
// Directed bench for l2_tcdm_arbiter with two masters and a one-cycle-latency L2 model.
module tb_l2_tcdm_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_req;
  logic [63:0] m_add;
  logic [1:0]  m_wen;
  logic [63:0] m_wdata;
  logic [7:0]  m_be;
  logic [1:0]  m_gnt;
  logic [1:0]  m_r_valid;
  logic [31:0] m_r_rdata;
  logic        s_req;
  logic [31:0] s_add;
  logic        s_wen;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic        s_gnt;
  logic [31:0] s_r_rdata;

  int n_checks;
  int n_pass;

  logic [31:0] mem [256];
  logic [1:0]  exp_alt [6];
  logic [1:0]  exp_t3_second;

  l2_tcdm_arbiter #(
    .NB_MASTERS (2),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_LATENCY(1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m_req_i    (m_req),
    .m_add_i    (m_add),
    .m_wen_i    (m_wen),
    .m_wdata_i  (m_wdata),
    .m_be_i     (m_be),
    .m_gnt_o    (m_gnt),
    .m_r_valid_o(m_r_valid),
    .m_r_rdata_o(m_r_rdata),
    .s_req_o    (s_req),
    .s_add_o    (s_add),
    .s_wen_o    (s_wen),
    .s_wdata_o  (s_wdata),
    .s_be_o     (s_be),
    .s_gnt_i    (s_gnt),
    .s_r_rdata_i(s_r_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L2 slave model: byte-enabled writes, read data one cycle after the accepted request.
  always @(posedge clk) begin
    if (rst) begin
      mem[4]    <= 32'hDEADBEEF;
      s_r_rdata <= '0;
    end else if (s_req && s_gnt) begin
      if (!s_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (s_be[b]) mem[s_add[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end else begin
        s_r_rdata <= mem[s_add[9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic req, input logic wen, input logic [31:0] add,
                       input logic [31:0] wdata, input logic [3:0] be);
    m_req[m]          = req;
    m_wen[m]          = wen;
    m_add[m*32 +: 32]   = add;
    m_wdata[m*32 +: 32] = wdata;
    m_be[m*4 +: 4]      = be;
  endtask

  task automatic idle();
    set_m(0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
`ifdef L2_ARB_JTAG_PRIO_EN
    exp_alt       = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    exp_t3_second = 2'b01;
`else
    exp_alt       = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    exp_t3_second = 2'b10;
`endif
    rst   = 1'b1;
    s_gnt = 1'b1;
    idle();
    // Requests during reset must not reach the slave.
    set_m(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b1, 32'h20, 32'h0, 4'hF);
    repeat (2) step();
    sample();
    check("rst_s_req", 64'(s_req), 64'd0);
    check("rst_gnt", 64'(m_gnt), 64'd0);
    check("rst_r_valid", 64'(m_r_valid), 64'd0);
    step();
    rst = 1'b0;
    idle();

    // Single read by m0.
    set_m(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
    sample();
    check("t1_gnt", 64'(m_gnt), 64'd1);
    check("t1_s_add", 64'(s_add), 64'h10);
    check("t1_s_wen", 64'(s_wen), 64'd1);
    check("t1_r_valid_early", 64'(m_r_valid), 64'd0);
    step();
    idle();
    sample();
    check("t1_r_valid", 64'(m_r_valid), 64'd1);
    check("t1_rdata", 64'(m_r_rdata), 64'hDEADBEEF);
    check("t1_gnt_idle", 64'(m_gnt), 64'd0);
    step();
    sample();
    check("t1_r_valid_pulse", 64'(m_r_valid), 64'd0);
    step();

    // m1 write, partial write, read back.
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h0000_0000, 4'hF);
    sample();
    check("t4_gnt0", 64'(m_gnt), 64'd2);
    check("t4_s_wdata0", 64'(s_wdata), 64'h0);
    check("t4_s_be0", 64'(s_be), 64'hF);
    check("t4_s_wen0", 64'(s_wen), 64'd0);
    step();
    set_m(1, 1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0011);
    sample();
    check("t4_gnt1", 64'(m_gnt), 64'd2);
    check("t4_r_valid0", 64'(m_r_valid), 64'd2);
    check("t4_s_be1", 64'(s_be), 64'h3);
    step();
    set_m(1, 1'b1, 1'b1, 32'h20, 32'h0, 4'hF);
    sample();
    check("t4_gnt2", 64'(m_gnt), 64'd2);
    check("t4_r_valid1", 64'(m_r_valid), 64'd2);
    step();
    idle();
    sample();
    check("t4_r_valid2", 64'(m_r_valid), 64'd2);
    check("t4_rdata", 64'(m_r_rdata), 64'h0000CCDD);
    step();

    // Continuous contention from both masters.
    set_m(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b1, 32'h20, 32'h0, 4'hF);
    for (int k = 0; k < 6; k++) begin
      sample();
      check("t2_gnt", 64'(m_gnt), 64'(exp_alt[k]));
      if (k > 0) begin
        check("t2_r_valid", 64'(m_r_valid), 64'(exp_alt[k-1]));
        check("t2_rdata", 64'(m_r_rdata),
              (exp_alt[k-1] == 2'b01) ? 64'hDEADBEEF : 64'h0000CCDD);
      end
      step();
    end
    idle();
    sample();
    check("t2_r_valid_last", 64'(m_r_valid), 64'(exp_alt[5]));
    step();

    // Slave stalls for three cycles.
    set_m(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b1, 32'h20, 32'h0, 4'hF);
    s_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t3_gnt_stall", 64'(m_gnt), 64'd0);
      check("t3_s_req_stall", 64'(s_req), 64'd1);
      check("t3_r_valid_stall", 64'(m_r_valid), 64'd0);
      step();
    end
    s_gnt = 1'b1;
    sample();
    check("t3_gnt_first", 64'(m_gnt), 64'd1);
    step();
    sample();
    check("t3_gnt_second", 64'(m_gnt), 64'(exp_t3_second));
    check("t3_r_valid_first", 64'(m_r_valid), 64'd1);
    step();
    idle();
    sample();
    check("t3_r_valid_second", 64'(m_r_valid), 64'(exp_t3_second));
    step();

    // Reset right after a read grant drops its response.
    set_m(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
    sample();
    check("t5_gnt", 64'(m_gnt), 64'd1);
    step();
    idle();
    rst = 1'b1;
    sample();
    check("t5_r_valid_in_rst", 64'(m_r_valid), 64'd0);
    step();
    rst = 1'b0;
    sample();
    check("t5_r_valid_after", 64'(m_r_valid), 64'd0);
    step();

    // Contention after reset starts from master 0.
    set_m(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b1, 32'h20, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      sample();
      check("t6_gnt", 64'(m_gnt), 64'(exp_alt[k]));
      if (k > 0) check("t6_r_valid", 64'(m_r_valid), 64'(exp_alt[k-1]));
      step();
    end
    idle();
    sample();
    check("t6_r_valid_last", 64'(m_r_valid), 64'(exp_alt[3]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
